// File: rtl/dram_access_ctrl.sv
// Data-memory initiator for the DLX memory stage: turns one-cycle load/store requests into
// ENABLE/READNOTWRITE/READY word transactions, with lane select, extension, sub-word RMW and timeout.
module dram_access_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MEM_REQ,
  input  logic                    MEM_WE,
  input  logic [1:0]              MEM_SIZE,
  input  logic                    MEM_SIGNED,
  input  logic [ADDRESS_SIZE-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]   MEM_WDATA,
  output logic [DATA_WIDTH-1:0]   MEM_RDATA,
  output logic                    MEM_DONE,
  output logic                    MEM_ERR,
  output logic                    MEM_BUSY,
  output logic [ADDRESS_SIZE-1:0] DRAM_ADDRESS,
  output logic                    DRAM_ENABLE,
  output logic                    DRAM_READNOTWRITE,
  input  logic                    DRAM_READY,
  inout  wire  [DATA_WIDTH-1:0]   DRAM_DATA
);

  localparam int CNT_W = $clog2(TIMEOUT);

  // The completion cycle is the first IDLE cycle, so there is no separate FIN state.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              size_q, size_d;
  logic                    sgn_q, sgn_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   bus_q, bus_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    en_q, en_d;
  logic                    rnw_q, rnw_d;
  logic                    oe_q, oe_d;
  logic                    busy_q, busy_d;
  logic                    timed_out;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Big-endian lane pick: byte offset 0 is the most significant byte.
  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [1:0] size, input logic sgn,
                                                         input logic [1:0] off);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    if (off[1]) h = word[15:0];
    else        h = word[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [1:0] size, input logic [1:0] off);
    logic [DATA_WIDTH-1:0] r;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r = {wd[7:0], word[23:0]};
          2'b01:   r = {word[31:24], wd[7:0], word[15:0]};
          2'b10:   r = {word[31:16], wd[7:0], word[7:0]};
          default: r = {word[31:8], wd[7:0]};
        endcase
      end
      2'b01: begin
        if (off[1]) r = {word[31:16], wd[15:0]};
        else        r = {wd[15:0], word[15:0]};
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // State and output registers; reset also aborts any transaction without a DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      bus_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      rnw_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      rnw_q   <= rnw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath: request capture, phase sequencing, per-phase timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    bus_d     = bus_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    case (state_q)
      S_IDLE: begin
        if (MEM_REQ) begin
          size_d  = MEM_SIZE;
          sgn_d   = MEM_SIGNED;
          off_d   = MEM_ADDR[1:0];
          wdata_d = MEM_WDATA;
          if (misaligned(MEM_SIZE, MEM_ADDR[1:0])) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d = {MEM_ADDR[ADDRESS_SIZE-1:2], 2'b00};
            cnt_d  = '0;
            if (!MEM_WE) begin
              state_d = S_RD;
            end else if (MEM_SIZE == 2'b10) begin
              state_d = S_WR;
              bus_d   = MEM_WDATA;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD, S_RMW_RD: begin
        if (DRAM_READY) begin
          if (state_q == S_RD) begin
            rdata_d = load_extract(DRAM_DATA, size_q, sgn_q, off_q);
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bus_d   = store_merge(DRAM_DATA, wdata_q, size_q, off_q);
            cnt_d   = '0;
            state_d = S_RMW_WR;
          end
        end else if (timed_out) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR, S_RMW_WR: begin
        if (DRAM_READY) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timed_out) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus controls follow the upcoming state so they are registered alongside it.
  always_comb begin
    en_d   = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
    oe_d   = (state_d == S_WR) || (state_d == S_RMW_WR);
    rnw_d  = ~oe_d;
  end

  assign MEM_RDATA         = rdata_q;
  assign MEM_DONE          = done_q;
  assign MEM_ERR           = err_q;
  assign MEM_BUSY          = busy_q;
  assign DRAM_ADDRESS      = addr_q;
  assign DRAM_ENABLE       = en_q;
  assign DRAM_READNOTWRITE = rnw_q;
  assign DRAM_DATA         = oe_q ? bus_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed self-checking bench for dram_access_ctrl with a small word memory answering the bus.
module tb_dram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_we, mem_signed;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata, dram_address;
  logic        mem_done, mem_err, mem_busy, dram_enable, dram_rnw;
  wire  [31:0] dram_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:15];
  logic        mem_load = 1'b0;
  logic        hold_low = 1'b0;
  int          delay = 0;
  int          rcnt = 0;

  int          en_cyc, rd_cyc, wr_cyc;
  logic [31:0] wr_val, op_rdata;
  logic        op_err, op_done, done_en, busy_first;

  always #5 clk = ~clk;

  wire dram_ready = dram_enable && !hold_low && (rcnt == delay);
  assign dram_data = (dram_enable && dram_rnw) ? mem[dram_address[5:2]] : 32'hzzzz_zzzz;

  // Memory model: READY after `delay` enabled cycles per phase, writes land on READY.
  always @(posedge clk) begin
    if (!dram_enable || dram_ready) rcnt <= 0;
    else rcnt <= rcnt + 1;
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8123_4567;
      mem[5] <= 32'h1122_3344;
    end else if (dram_enable && !dram_rnw && dram_ready) begin
      mem[dram_address[5:2]] <= dram_data;
    end
  end

  dram_access_ctrl #(.DATA_WIDTH(32), .ADDRESS_SIZE(32), .TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst), .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_SIZE(mem_size),
    .MEM_SIGNED(mem_signed), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .MEM_DONE(mem_done), .MEM_ERR(mem_err), .MEM_BUSY(mem_busy),
    .DRAM_ADDRESS(dram_address), .DRAM_ENABLE(dram_enable), .DRAM_READNOTWRITE(dram_rnw),
    .DRAM_READY(dram_ready), .DRAM_DATA(dram_data)
  );

  // Issues one request at a negedge and follows it to its DONE cycle (left at that negedge).
  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    en_cyc = 0; rd_cyc = 0; wr_cyc = 0; wr_val = 32'h0; op_err = 1'b0; op_done = 1'b0;
    done_en = 1'b0; op_rdata = 32'h0;
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sg; mem_addr = a; mem_wdata = wd;
    @(negedge clk);
    mem_req = 1'b0;
    busy_first = mem_busy;
    for (int i = 0; i < 100 && !op_done; i++) begin
      if (mem_done) begin
        op_done = 1'b1; op_err = mem_err; op_rdata = mem_rdata; done_en = dram_enable;
      end else begin
        if (dram_enable) en_cyc++;
        if (dram_enable && dram_rnw) rd_cyc++;
        if (dram_enable && !dram_rnw) begin wr_cyc++; wr_val = dram_data; end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_load = 1'b1;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    checks++; if ({dram_enable, dram_rnw, mem_done, mem_err, mem_busy} !== 5'b01000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 01000", {dram_enable, dram_rnw, mem_done, mem_err, mem_busy}); end
    checks++; if (dram_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", dram_address); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    delay = 2;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL wl_done: got %b expected 1", op_done); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL wl_busy: got %b expected 1", busy_first); end
    checks++; if (en_cyc != 3) begin errors++; $display("FAIL wl_enable_cycles: got %0d expected 3", en_cyc); end
    checks++; if (op_rdata !== 32'h8123_4567) begin errors++; $display("FAIL wl_rdata: got %h expected 81234567", op_rdata); end
    checks++; if ({op_err, done_en, mem_busy} !== 3'b000) begin errors++; $display("FAIL wl_done_cycle: got %b expected 000", {op_err, done_en, mem_busy}); end
    checks++; if (dram_address !== 32'h10) begin errors++; $display("FAIL wl_addr: got %h expected 00000010", dram_address); end
    @(negedge clk);
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL wl_done_pulse: got %b expected 0", mem_done); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] addrs [5] = '{32'h11, 32'h10, 32'h10, 32'h10, 32'h12};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        sgns  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [5] = '{32'h0000_0023, 32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8123, 32'h0000_4567};
    delay = 1;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, sizes[i], sgns[i], addrs[i], 32'h0);
      checks++; if (op_rdata !== exps[i] || op_err !== 1'b0 || op_done !== 1'b1) begin
        errors++; $display("FAIL subword_load[%0d]: got %h err %b done %b expected %h err 0 done 1",
                           i, op_rdata, op_err, op_done, exps[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_rmw_store();
    delay = 1;
    run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
    checks++; if (rd_cyc != 2 || wr_cyc != 2) begin errors++; $display("FAIL rmw_phases: got rd %0d wr %0d expected 2 2", rd_cyc, wr_cyc); end
    checks++; if (wr_val !== 32'h8123_BEEF) begin errors++; $display("FAIL rmw_half_bus: got %h expected 8123beef", wr_val); end
    checks++; if (mem[4] !== 32'h8123_BEEF || op_err !== 1'b0) begin errors++; $display("FAIL rmw_half_mem: got %h err %b expected 8123beef err 0", mem[4], op_err); end
    @(negedge clk);
    run_op(1'b1, 2'b00, 1'b0, 32'h17, 32'h1234_56AB);
    checks++; if (mem[5] !== 32'h1122_33AB) begin errors++; $display("FAIL rmw_byte_mem: got %h expected 112233ab", mem[5]); end
    @(negedge clk);
    delay = 0;
    run_op(1'b1, 2'b10, 1'b0, 32'h18, 32'hDEAD_BEEF);
    checks++; if (en_cyc != 1 || rd_cyc != 0) begin errors++; $display("FAIL word_store_cycles: got en %0d rd %0d expected 1 0", en_cyc, rd_cyc); end
    checks++; if (mem[6] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_store_mem: got %h expected deadbeef", mem[6]); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    delay = 1;
    run_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    checks++; if ({op_done, op_err, done_en} !== 3'b110 || en_cyc != 0) begin
      errors++; $display("FAIL mis_word_load: got done/err/en %b en_cyc %0d expected 110 0", {op_done, op_err, done_en}, en_cyc); end
    checks++; if (op_rdata !== 32'h0000_4567) begin errors++; $display("FAIL mis_rdata: got %h expected 00004567", op_rdata); end
    @(negedge clk);
    run_op(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_CAFE);
    checks++; if ({op_done, op_err} !== 2'b11 || en_cyc != 0 || mem[4] !== 32'h8123_BEEF) begin
      errors++; $display("FAIL mis_half_store: got done/err %b en_cyc %0d mem %h expected 11 0 8123beef", {op_done, op_err}, en_cyc, mem[4]); end
    @(negedge clk);
    run_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    checks++; if ({op_done, op_err} !== 2'b11 || en_cyc != 0) begin
      errors++; $display("FAIL mis_size11: got done/err %b en_cyc %0d expected 11 0", {op_done, op_err}, en_cyc); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    hold_low = 1'b1;
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (en_cyc != 16) begin errors++; $display("FAIL to_enable_cycles: got %0d expected 16", en_cyc); end
    checks++; if ({op_done, op_err, done_en} !== 3'b110) begin errors++; $display("FAIL to_err: got %b expected 110", {op_done, op_err, done_en}); end
    checks++; if (op_rdata !== 32'h0000_4567) begin errors++; $display("FAIL to_rdata: got %h expected 00004567", op_rdata); end
    hold_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int dones;
    hold_low = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h10;
    @(negedge clk);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dram_enable !== 1'b1) begin errors++; $display("FAIL rst_pre_enable: got %b expected 1", dram_enable); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({dram_enable, mem_busy, mem_done, dram_rnw} !== 4'b0001 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_abort: got %b rdata %h expected 0001 0", {dram_enable, mem_busy, mem_done, dram_rnw}, mem_rdata); end
    rst = 1'b0; hold_low = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (mem_done || dram_enable) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    int spurious;
    delay = 1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h14;
    @(negedge clk);
    mem_req = 1'b0;
    for (int i = 0; i < 50 && !mem_done; i++) @(negedge clk);
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h1122_33AB || dram_enable !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got done %b rdata %h en %b expected 1 112233ab 0", mem_done, mem_rdata, dram_enable); end
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0; mem_addr = 32'h10;
    @(negedge clk);
    checks++; if ({dram_enable, mem_busy} !== 2'b11) begin errors++; $display("FAIL b2b_accept: got %b expected 11", {dram_enable, mem_busy}); end
    mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h18; mem_wdata = 32'h0;
    @(negedge clk);
    mem_req = 1'b0;
    for (int i = 0; i < 50 && !mem_done; i++) @(negedge clk);
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h0000_0081 || mem_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got done %b rdata %h err %b expected 1 00000081 0", mem_done, mem_rdata, mem_err); end
    spurious = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (dram_enable) spurious++; end
    checks++; if (spurious != 0 || mem[6] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_busy_ignored: got en %0d mem %h expected 0 deadbeef", spurious, mem[6]); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_rmw_store();
    test_misaligned();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
